// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and constants for the program loader slice.
package rv32i_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RELEASE, ST_RUN} loader_state_t;
  localparam logic TGT_IMEM = 1'b0;
  localparam logic TGT_DMEM = 1'b1;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from a byte stream, zero-padding a short final group.
module byte_packer
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_fire,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        partial
);
  logic [1:0]  idx_q, idx_d;
  logic [23:0] acc_q, acc_d;
  // acc_q holds only the bytes already received, so upper lanes are zero for padding
  always_comb begin
    word       = {8'h00, acc_q} | ({24'h0, in_byte} << {idx_q, 3'b000});
    word_valid = in_fire && (idx_q == 2'(WORD_BYTES - 1) || in_last);
    partial    = in_fire && in_last && idx_q != 2'(WORD_BYTES - 1);
    idx_d      = (clear || word_valid) ? 2'd0 : in_fire ? idx_q + 2'd1 : idx_q;
    acc_d      = (clear || word_valid) ? 24'h0 : in_fire ? word[23:0] : acc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: fills instruction or data memory from a byte stream, then releases the core.
module imem_loader
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              target,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              core_enable,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);
  loader_state_t     state_q, state_d;
  logic              tgt_q, tgt_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              err_q, err_d;
  logic              imem_we_q, imem_we_d, dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              core_rst_q, core_rst_d, core_enable_q, core_enable_d;
  logic              fire, go, wr, word_valid, partial;
  logic [31:0]       word;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (go),
    .in_fire   (fire),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .word_valid(word_valid),
    .word      (word),
    .partial   (partial)
  );

  // wc_q doubles as the write address; its top bit marks a full memory
  always_comb begin
    fire          = in_valid && state_q == ST_LOAD;
    go            = start && (state_q == ST_IDLE || state_q == ST_RUN);
    wr            = word_valid && !wc_q[ADDR_W];
    state_d       = go ? ST_LOAD
                  : (fire && in_last) ? ST_RELEASE
                  : state_q == ST_RELEASE ? ST_RUN : state_q;
    tgt_d         = go ? target : tgt_q;
    wc_d          = go ? '0 : wr ? wc_q + 1'b1 : wc_q;
    err_d         = !go && (err_q || partial || (word_valid && wc_q[ADDR_W]));
    imem_we_d     = wr && tgt_q == TGT_IMEM;
    dmem_we_d     = wr && tgt_q == TGT_DMEM;
    mem_addr_d    = wr ? wc_q[ADDR_W-1:0] : mem_addr_q;
    mem_wdata_d   = wr ? word : mem_wdata_q;
    core_rst_d    = state_d == ST_IDLE || state_d == ST_LOAD || state_q == ST_LOAD;
    core_enable_d = state_d == ST_RUN && state_q == ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      tgt_q         <= TGT_IMEM;
      wc_q          <= '0;
      err_q         <= 1'b0;
      imem_we_q     <= 1'b0;
      dmem_we_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      core_rst_q    <= 1'b1;
      core_enable_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      wc_q          <= wc_d;
      err_q         <= err_d;
      imem_we_q     <= imem_we_d;
      dmem_we_q     <= dmem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      core_rst_q    <= core_rst_d;
      core_enable_q <= core_enable_d;
    end
  end

  assign in_ready    = state_q == ST_LOAD;
  assign busy        = state_q == ST_LOAD || state_q == ST_RELEASE;
  assign imem_we     = imem_we_q;
  assign dmem_we     = dmem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign core_rst    = core_rst_q;
  assign core_enable = core_enable_q;
  assign err         = err_q;
  assign word_count  = wc_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vector table plus multi-cycle sequences for imem_loader at ADDR_W=8 and ADDR_W=2.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, target = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] in_byte = 8'h00;
  always #5 clk = ~clk;

  logic rdy8, iwe8, dwe8, crst8, cen8, busy8, err8;
  logic [7:0] addr8;
  logic [31:0] wd8;
  logic [8:0] wc8;
  logic rdy2, iwe2, dwe2, crst2, cen2, busy2, err2;
  logic [1:0] addr2;
  logic [31:0] wd2;
  logic [2:0] wc2;

  imem_loader #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .target(target), .in_valid(in_valid),
    .in_byte(in_byte), .in_last(in_last), .in_ready(rdy8), .imem_we(iwe8), .dmem_we(dwe8),
    .mem_addr(addr8), .mem_wdata(wd8), .core_rst(crst8), .core_enable(cen8), .busy(busy8),
    .err(err8), .word_count(wc8));

  imem_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .target(target), .in_valid(in_valid),
    .in_byte(in_byte), .in_last(in_last), .in_ready(rdy2), .imem_we(iwe2), .dmem_we(dwe2),
    .mem_addr(addr2), .mem_wdata(wd2), .core_rst(crst2), .core_enable(cen2), .busy(busy2),
    .err(err2), .word_count(wc2));

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic d;
    logic [7:0] a;
    logic [31:0] w;
  } wr_t;
  wr_t q8[$], q2[$], eq[$];

  always @(negedge clk) begin
    if (iwe8 || dwe8) q8.push_back('{dwe8, addr8, wd8});
    if (iwe2 || dwe2) q2.push_back('{dwe2, {6'd0, addr2}, wd2});
    if ((iwe8 && dwe8) || (iwe2 && dwe2)) begin
      n_chk++;
      n_fail++;
      $display("FAIL both_strobes: imem_we=%b/%b dmem_we=%b/%b required not both high", iwe8, iwe2, dwe8, dwe2);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_start(input logic t);
    start = 1'b1;
    target = t;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic l, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_byte = b;
    in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_run();
    int k = 0;
    while (!cen8 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("release_timeout", {31'd0, cen8}, 32'd1);
  endtask

  task automatic cmp_writes(input string nm, input bit use2);
    wr_t got[$];
    if (use2) got = q2; else got = q8;
    chk({nm, "_count"}, got.size(), eq.size());
    for (int i = 0; i < got.size() && i < eq.size(); i++) begin
      chk($sformatf("%s_dmem%0d", nm, i), {31'd0, got[i].d}, {31'd0, eq[i].d});
      chk($sformatf("%s_addr%0d", nm, i), {24'd0, got[i].a}, {24'd0, eq[i].a});
      chk($sformatf("%s_data%0d", nm, i), got[i].w, eq[i].w);
    end
  endtask

  typedef struct {
    logic st, tg, v;
    logic [7:0] b;
    logic l;
    logic rdy, iwe, dwe;
    logic [7:0] addr;
    logic [31:0] wd;
    logic crst, cen, busy, err;
    logic [8:0] wc;
  } vec_t;
  vec_t tab[11];

  initial begin
    tab[0]  = '{1, 0, 1, 8'hff, 0, 1, 0, 0, 8'd0, 32'h0,  1, 0, 1, 0, 9'd0};
    tab[1]  = '{0, 0, 1, 8'h33, 0, 1, 0, 0, 8'd0, 32'h0,  1, 0, 1, 0, 9'd0};
    tab[2]  = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 8'd0, 32'h0,  1, 0, 1, 0, 9'd0};
    tab[3]  = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 8'd0, 32'h0,  1, 0, 1, 0, 9'd0};
    tab[4]  = '{0, 0, 1, 8'h00, 0, 1, 1, 0, 8'd0, 32'h33, 1, 0, 1, 0, 9'd1};
    tab[5]  = '{0, 0, 1, 8'hb3, 0, 1, 0, 0, 8'd0, 32'h33, 1, 0, 1, 0, 9'd1};
    tab[6]  = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 8'd0, 32'h33, 1, 0, 1, 0, 9'd1};
    tab[7]  = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 8'd0, 32'h33, 1, 0, 1, 0, 9'd1};
    tab[8]  = '{0, 0, 1, 8'h00, 1, 0, 1, 0, 8'd1, 32'hb3, 1, 0, 1, 0, 9'd2};
    tab[9]  = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd1, 32'hb3, 0, 0, 0, 0, 9'd2};
    tab[10] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd1, 32'hb3, 0, 1, 0, 0, 9'd2};

    repeat (2) @(posedge clk); #1;
    chk("rst_core_rst", {31'd0, crst8}, 32'd1);
    chk("rst_core_en", {31'd0, cen8}, 32'd0);
    chk("rst_ready", {31'd0, rdy8}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_wc", {23'd0, wc8}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      start = tab[i].st; target = tab[i].tg; in_valid = tab[i].v;
      in_byte = tab[i].b; in_last = tab[i].l;
      @(posedge clk); #1;
      chk($sformatf("t%0d_ready", i), {31'd0, rdy8}, {31'd0, tab[i].rdy});
      chk($sformatf("t%0d_imem_we", i), {31'd0, iwe8}, {31'd0, tab[i].iwe});
      chk($sformatf("t%0d_dmem_we", i), {31'd0, dwe8}, {31'd0, tab[i].dwe});
      chk($sformatf("t%0d_addr", i), {24'd0, addr8}, {24'd0, tab[i].addr});
      chk($sformatf("t%0d_wdata", i), wd8, tab[i].wd);
      chk($sformatf("t%0d_core_rst", i), {31'd0, crst8}, {31'd0, tab[i].crst});
      chk($sformatf("t%0d_core_en", i), {31'd0, cen8}, {31'd0, tab[i].cen});
      chk($sformatf("t%0d_busy", i), {31'd0, busy8}, {31'd0, tab[i].busy});
      chk($sformatf("t%0d_err", i), {31'd0, err8}, {31'd0, tab[i].err});
      chk($sformatf("t%0d_wc", i), {23'd0, wc8}, {23'd0, tab[i].wc});
    end
    start = 0; in_valid = 0; in_last = 0;

    // partial final word, reloading from RUN
    q8.delete(); q2.delete(); eq.delete();
    do_start(1'b0);
    chk("reload_core_rst", {31'd0, crst8}, 32'd1);
    chk("reload_core_en", {31'd0, cen8}, 32'd0);
    chk("reload_wc", {23'd0, wc8}, 32'd0);
    for (int i = 1; i <= 6; i++) send(8'(i), i == 6, 0);
    wait_run();
    eq.push_back('{1'b0, 8'd0, 32'h04030201});
    eq.push_back('{1'b0, 8'd1, 32'h00000605});
    cmp_writes("partial", 1'b0);
    chk("partial_err", {31'd0, err8}, 32'd1);
    chk("partial_wc", {23'd0, wc8}, 32'd2);

    // overflow on the 4-word instance
    q8.delete(); q2.delete(); eq.delete();
    do_start(1'b0);
    chk("ovf_err_cleared", {31'd0, err8}, 32'd0);
    for (int j = 0; j < 5; j++)
      for (int k = 0; k < 4; k++) send(8'(16 * j + k + 1), j == 4 && k == 3, 0);
    wait_run();
    chk("ovf_released", {31'd0, cen2}, 32'd1);
    for (int j = 0; j < 4; j++)
      eq.push_back('{1'b0, 8'(j), {8'(16*j+4), 8'(16*j+3), 8'(16*j+2), 8'(16*j+1)}});
    cmp_writes("ovf", 1'b1);
    chk("ovf_err", {31'd0, err2}, 32'd1);
    chk("ovf_wc", {29'd0, wc2}, 32'd4);
    chk("big_wc", {23'd0, wc8}, 32'd5);
    chk("big_err", {31'd0, err8}, 32'd0);

    // data memory target with random valid gaps
    q8.delete(); q2.delete(); eq.delete();
    do_start(1'b1);
    begin
      logic [7:0] bs [8];
      for (int i = 0; i < 8; i++) bs[i] = 8'(8'hc1 + 8'(i * 7));
      for (int i = 0; i < 8; i++) send(bs[i], i == 7, int'($urandom_range(0, 3)));
      eq.push_back('{1'b1, 8'd0, {bs[3], bs[2], bs[1], bs[0]}});
      eq.push_back('{1'b1, 8'd1, {bs[7], bs[6], bs[5], bs[4]}});
    end
    wait_run();
    cmp_writes("dmem", 1'b0);

    // reset in the middle of a word
    q8.delete(); q2.delete(); eq.delete();
    do_start(1'b0);
    send(8'haa, 1'b0, 0);
    send(8'hbb, 1'b0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_core_rst", {31'd0, crst8}, 32'd1);
    chk("mid_rst_core_en", {31'd0, cen8}, 32'd0);
    chk("mid_rst_ready", {31'd0, rdy8}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy8}, 32'd0);
    chk("mid_rst_addr", {24'd0, addr8}, 32'd0);
    chk("mid_rst_wdata", wd8, 32'd0);
    chk("mid_rst_wc", {23'd0, wc8}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    do_start(1'b0);
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b0, 0);
    send(8'h33, 1'b0, 0);
    send(8'h44, 1'b1, 0);
    wait_run();
    eq.push_back('{1'b0, 8'd0, 32'h44332211});
    cmp_writes("after_rst", 1'b0);
    chk("after_rst_err", {31'd0, err8}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Hardware program loader that fills the RV32I core's instruction or data memory from a byte stream and then releases the core, replacing the simulation-only file preload with a path that works on silicon and FPGA. It sits between a byte source (UART receiver, JTAG bridge or bench driver) and the write ports of the instruction and data memories. It also owns the core's reset/enable sequencing. During a load it holds the core in reset with `enable` low; after the last word is written it lowers reset and then raises enable.

## Interface
- `ADDR_W`, default 8: word-address width; memory depth is `2**ADDR_W` words.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a load. Sampled in IDLE and RUN; ignored in LOAD and RELEASE.
- `target`  in  1  sampled with `start`: 0 selects instruction memory, 1 selects data memory.
- `in_valid`  in  1  byte-stream valid.
- `in_byte`  in  8  stream byte.
- `in_last`  in  1  marks the final byte of the image; qualified by `in_valid`.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `dmem_we`  out  1  data-memory write strobe.
- `mem_addr`  out  ADDR_W  word address shared by both memories.
- `mem_wdata`  out  32  word to write.
- `core_rst`  out  1  core reset, active-high.
- `core_enable`  out  1  core enable.
- `busy`  out  1  high in LOAD and RELEASE.
- `err`  out  1  sticky; set on overflow or on a partial final word; cleared by the next `start` or by `rst`.
- `word_count`  out  ADDR_W+1  number of words written by the last load.

## Operation
- A byte transfers on any cycle where `in_valid && in_ready`.
- FSM states: IDLE, LOAD, RELEASE, RUN.
- IDLE (reset state):
  - `core_rst=1`, `core_enable=0`, `in_ready=0`.
  - On `start`: latch `target`, clear the address, byte index, `word_count` and `err`, then go to LOAD.
- LOAD:
  - `in_ready=1` every cycle; the loader never back-pressures.
  - Bytes pack little-endian: first byte of each group to `[7:0]`, fourth byte to `[31:24]`.
  - After the 4th byte, register a write of the assembled word at the current address. Then increment the address and `word_count`.
  - On `in_last` with fewer than 4 bytes in the group: zero-pad the upper bytes, write the word, set `err`.
  - Overflow: a word completing when `word_count == 2**ADDR_W` is dropped (no strobe) and sets `err`. Bytes are still accepted until `in_last`.
  - After the write for `in_last` is issued, go to RELEASE. If `in_last` arrives with no pending word, the last write has already been issued.
- RELEASE lasts one cycle: `core_rst=0`, `core_enable=0`. Then go to RUN.
- RUN: `core_rst=0`, `core_enable=1`, `in_ready=0`. On `start`, go to LOAD: `core_rst=1` and `core_enable=0` on the next edge, and the new `target` is latched.
- The address counter is ADDR_W+1 bits wide and never wraps into low addresses.
- Only the strobe selected by the latched `target` ever pulses; `imem_we` and `dmem_we` are never high together.
- `rst` low in any state returns to IDLE on the next edge, with all outputs at their reset values. Any half-assembled word is discarded.

## Timing
- Reset values: `core_rst=1`, `core_enable=0`, `in_ready=0`, `imem_we=0`, `dmem_we=0`, `mem_addr=0`, `mem_wdata=0`, `busy=0`, `err=0`, `word_count=0`.
- `start` at edge N: state is LOAD and `in_ready=1` after edge N.
- Write latency: a word whose 4th byte is accepted at edge N has its write strobe high during cycle N+1. `mem_addr`, `mem_wdata` and the strobe are all registered, and the strobe is high for exactly one cycle.
- `in_last` accepted at edge N: strobe (if any) in cycle N+1, RELEASE in cycle N+1, `core_rst=0` from edge N+1, `core_enable=1` from edge N+2.
- Back-to-back bytes at full rate give one write every 4 cycles. Gaps in `in_valid` only stall packing.
- `start` together with `in_valid` in IDLE: the byte is not accepted, because `in_ready` is 0 in that cycle.

## Structure
- The shared package `rv32i_pkg` holds:
  - the FSM state enum `loader_state_t`;
  - the constants `TGT_IMEM=1'b0` and `TGT_DMEM=1'b1`;
  - `WORD_BYTES=4`.
- One natural sub-module, `byte_packer`: it holds the byte index, the shift/assembly register and the word-complete/pad logic, and emits `word_valid`, `word` and `partial`. The FSM, address counter and core sequencing stay in `imem_loader`.

## Test plan
- Load into imem with `ADDR_W=8`, bytes `33 00 00 00 b3 00 00 00` (last on the 8th byte):
  - two `imem_we` pulses, writing `0x00000033` at address 0 and `0x000000b3` at address 1;
  - `word_count=2`, `err=0`;
  - `core_rst` falls 1 cycle after the second write, `core_enable` rises 1 cycle after that.
- Partial image: 6 bytes `01 02 03 04 05 06`, last on byte 6:
  - writes `0x04030201` at address 0 and `0x00000605` at address 1;
  - `err=1`, `word_count=2`.
- Overflow with `ADDR_W=2`: stream 5 full words:
  - 4 writes at addresses 0-3, the 5th word produces no strobe;
  - `err=1`, `word_count=4`, core is released after `in_last`.
- `target=1` with bytes separated by random `in_valid` gaps: only `dmem_we` pulses, with the same packed values as a gap-free run.
- Re-load from RUN: `start` drops `core_enable` and raises `core_rst` on the next edge, and `err` and `word_count` are cleared.
- `rst` low in the middle of a word (after 2 bytes): next state is IDLE with all outputs at their reset values. A new load then starts at address 0 with byte index 0.
